// File: rtl/tnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tnn_pkg
// Description : Shared constants, threshold-table types and reset defaults for
//               the TNN input quantizer and its thermometer counter.
// Revision    : 1.0 - initial release
// ============================================================================
package tnn_pkg;

    localparam int N_FEAT = 5;
    localparam int IN_W   = 8;
    localparam int Q_W    = 3;
    localparam int N_THR  = (2 ** Q_W) - 1;

    typedef logic [N_THR-1:0][IN_W-1:0] thr_row_t;
    typedef thr_row_t [N_FEAT-1:0]      thr_table_t;

    // Uniform bins: threshold k sits at the upper edge of bin k.
    function automatic thr_table_t default_thr();
        thr_table_t t;
        for (int f = 0; f < N_FEAT; f++) begin
            for (int k = 0; k < N_THR; k++) begin
                t[f][k] = IN_W'(32 * (k + 1));
            end
        end
        return t;
    endfunction

endpackage : tnn_pkg
`default_nettype wire

// File: rtl/tnn_thermo_count.sv
`default_nettype none
// ============================================================================
// Module      : tnn_thermo_count
// Description : Counts how many of the row thresholds the sample meets or
//               exceeds; order of thresholds does not matter.
// Revision    : 1.0 - initial release
// ============================================================================
module tnn_thermo_count
    import tnn_pkg::*;
(
    input  logic [IN_W-1:0] sample,
    input  thr_row_t        thr,
    output logic [Q_W-1:0]  q
);

    logic [N_THR-1:0] w_ge;

    for (genvar k = 0; k < N_THR; k++) begin : g_cmp
        assign w_ge[k] = (sample >= thr[k]);
    end

    always_comb begin
        q = '0;
        for (int k = 0; k < N_THR; k++) begin
            q = q + Q_W'(w_ge[k]);
        end
    end

endmodule : tnn_thermo_count
`default_nettype wire

// File: rtl/tnn_input_quantizer.sv
`default_nettype none
// ============================================================================
// Module      : tnn_input_quantizer
// Description : Quantizes serial feature samples against a programmable table
//               and packs N_FEAT of them into a double-buffered output vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tnn_input_quantizer
    import tnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_FEAT*Q_W-1:0]   m_vec,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_feat,
    input  logic [2:0]              cfg_idx,
    input  logic [IN_W-1:0]         cfg_data,
    output logic                    err_frame,
    input  logic                    cfg_clr_err
);

    localparam logic [2:0] c_last_slot = 3'(N_FEAT - 1);

    thr_table_t              r_thr;
    logic [2:0]              r_cnt;
    logic [N_FEAT*Q_W-1:0]   r_collect;
    logic                    r_collect_full;
    logic                    r_m_valid;
    logic [N_FEAT*Q_W-1:0]   r_m_vec;
    logic                    r_err;

    logic [Q_W-1:0]          w_q;
    logic [N_FEAT*Q_W-1:0]   w_vec_next;
    logic                    w_accept;
    logic                    w_at_last_slot;
    logic                    w_complete;
    logic                    w_frame_err;
    logic                    w_drain;
    logic                    w_cfg_hit;

    tnn_thermo_count u_thermo (
        .sample (s_data),
        .thr    (r_thr[r_cnt]),
        .q      (w_q)
    );

    assign s_ready        = !r_collect_full;
    assign m_valid        = r_m_valid;
    assign m_vec          = r_m_vec;
    assign err_frame      = r_err;

    assign w_accept       = s_valid && s_ready;
    assign w_at_last_slot = (r_cnt == c_last_slot);
    assign w_complete     = w_accept && s_last && w_at_last_slot;
    assign w_frame_err    = w_accept && (s_last != w_at_last_slot);
    assign w_drain        = r_m_valid && m_ready;
    assign w_cfg_hit      = cfg_we && (cfg_feat < 3'(N_FEAT)) && (cfg_idx != 3'(N_THR));

    always_comb begin
        w_vec_next                    = r_collect;
        w_vec_next[r_cnt*Q_W +: Q_W]  = w_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_thr          <= default_thr();
            r_cnt          <= '0;
            r_collect      <= '0;
            r_collect_full <= 1'b0;
            r_m_valid      <= 1'b0;
            r_m_vec        <= '0;
            r_err          <= 1'b0;
        end else begin
            // The quantizer reads r_thr before this write lands, so a
            // same-cycle write never affects the sample being accepted.
            if (w_cfg_hit) begin
                r_thr[cfg_feat][cfg_idx] <= cfg_data;
            end

            if (w_accept) begin
                r_collect <= w_vec_next;
                r_cnt     <= (w_complete || w_frame_err) ? 3'd0 : r_cnt + 3'd1;
            end

            if (w_complete && (!r_m_valid || m_ready)) begin
                r_m_vec   <= w_vec_next;
                r_m_valid <= 1'b1;
            end else if (r_collect_full && w_drain) begin
                r_m_vec        <= r_collect;
                r_m_valid      <= 1'b1;
                r_collect_full <= 1'b0;
            end else if (w_drain) begin
                r_m_valid <= 1'b0;
            end else if (w_complete) begin
                r_collect_full <= 1'b1;
            end

            if (w_frame_err) begin
                r_err <= 1'b1;
            end else if (cfg_clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule : tnn_input_quantizer
`default_nettype wire

// File: tb/tb_tnn_input_quantizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tnn_input_quantizer
// Description : Scoreboard bench for tnn_input_quantizer with a table-based
//               reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tnn_input_quantizer;
    import tnn_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [14:0] m_vec;
    logic        cfg_we;
    logic [2:0]  cfg_feat;
    logic [2:0]  cfg_idx;
    logic [7:0]  cfg_data;
    logic        err_frame;
    logic        cfg_clr_err;

    always #5 clk = ~clk;

    tnn_input_quantizer dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_vec       (m_vec),
        .cfg_we      (cfg_we),
        .cfg_feat    (cfg_feat),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .err_frame   (err_frame),
        .cfg_clr_err (cfg_clr_err)
    );

    int          thr_m [5][7];
    logic [14:0] sb [$];
    int          part [5];
    int          midx;
    bit          err_exp;
    int          n_checks;
    int          n_fail;
    int          n_out;
    bit          ready_level;
    bit          rnd_mode;
    int          vecbuf [5];
    int          cyc;
    int          last_acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    function automatic int quant(int f, int d);
        int c = 0;
        for (int k = 0; k < 7; k++) if (d >= thr_m[f][k]) c++;
        return c;
    endfunction

    function automatic void model_reset();
        for (int f = 0; f < 5; f++)
            for (int k = 0; k < 7; k++) thr_m[f][k] = 32 * (k + 1);
        sb.delete();
        midx    = 0;
        err_exp = 1'b0;
    endfunction

    function automatic void model_beat(int d, bit last);
        logic [14:0] v;
        if (last != (midx == 4)) begin
            err_exp = 1'b1;
            midx    = 0;
        end else begin
            part[midx] = quant(midx, d);
            if (midx == 4) begin
                for (int i = 0; i < 5; i++) v[i*3 +: 3] = 3'(part[i]);
                sb.push_back(v);
                midx = 0;
            end else begin
                midx++;
            end
        end
    endfunction

    task automatic send_beat(input int d, input bit last);
        bit acc = 1'b0;
        bit was_ready;
        s_valid = 1'b1;
        s_data  = 8'(d);
        s_last  = last;
        for (int t = 0; t < 300 && !acc; t++) begin
            was_ready = s_ready;
            @(posedge clk);
            #1;
            if (was_ready) begin
                model_beat(d, last);
                acc          = 1'b1;
                last_acc_cyc = cyc;
            end
            if (cfg_we) begin
                if (cfg_feat < 5 && cfg_idx < 7) thr_m[cfg_feat][cfg_idx] = cfg_data;
                cfg_we = 1'b0;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_vec();
        for (int i = 0; i < 5; i++) send_beat(vecbuf[i], i == 4);
    endtask

    task automatic rand_vec();
        for (int i = 0; i < 5; i++) vecbuf[i] = $urandom_range(0, 255);
    endtask

    task automatic cfg_write(input int f, input int k, input int v);
        cfg_we   = 1'b1;
        cfg_feat = 3'(f);
        cfg_idx  = 3'(k);
        cfg_data = 8'(v);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (f < 5 && k < 7) thr_m[f][k] = v;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int out0;
        int first_acc;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        cfg_we = 1'b0; cfg_feat = '0; cfg_idx = '0; cfg_data = '0; cfg_clr_err = 1'b0;
        m_ready = 1'b0; ready_level = 1'b0; rnd_mode = 1'b0;
        n_checks = 0; n_fail = 0; n_out = 0; cyc = 0; last_acc_cyc = 0;
        model_reset();

        fork
            forever begin
                @(posedge clk);
                #2;
                m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_level;
            end
            begin : monitor
                bit          stall_prev = 1'b0;
                logic [14:0] stall_vec  = '0;
                logic [14:0] exp_v;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        stall_prev = 1'b0;
                    end else begin
                        if (stall_prev) begin
                            check("stall_valid", int'(m_valid), 1);
                            check("stall_vec", int'(m_vec), int'(stall_vec));
                        end
                        if (m_valid && m_ready) begin
                            n_out++;
                            if (sb.size() == 0) begin
                                check("out_without_expect", sb.size(), 1);
                            end else begin
                                exp_v = sb.pop_front();
                                check("m_vec", int'(m_vec), int'(exp_v));
                            end
                        end
                        stall_prev = m_valid && !m_ready;
                        stall_vec  = m_vec;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_vec", int'(m_vec), 0);
        check("rst_err", int'(err_frame), 0);
        check("rst_s_ready", int'(s_ready), 1);

        // Default-table vector and one-cycle latency
        vecbuf = '{0, 31, 32, 223, 255};
        send_vec();
        check("lat_m_valid", int'(m_valid), 1);
        check("lat_m_vec", int'(m_vec), 15'h7C40);
        ready_level = 1'b1;
        wait_drain();

        // Back-pressure: one held, one collected, third stalled
        ready_level = 1'b0;
        rand_vec(); send_vec();
        rand_vec(); send_vec();
        check("full_s_ready", int'(s_ready), 0);
        s_valid = 1'b1; s_data = 8'd77; s_last = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("stalled_s_ready", int'(s_ready), 0);
        check("held_first", int'(m_vec), int'(sb[0]));
        ready_level = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("release_s_ready", int'(s_ready), 1);
        check("release_valid", int'(m_valid), 1);
        check("release_second", int'(m_vec), int'(sb[0]));
        wait_drain();

        // Early s_last framing error
        send_beat(10, 1'b0); send_beat(20, 1'b0); send_beat(30, 1'b1);
        check("err_set", int'(err_frame), int'(err_exp));
        check("err_no_valid", int'(m_valid), 0);
        rand_vec(); send_vec();
        wait_drain();
        check("err_sticky", int'(err_frame), 1);
        cfg_clr_err = 1'b1;
        @(posedge clk);
        #1;
        cfg_clr_err = 1'b0;
        err_exp = 1'b0;
        check("err_cleared", int'(err_frame), 0);

        // Programmed and non-monotonic thresholds on feature 2
        for (int k = 0; k < 7; k++) cfg_write(2, k, 10 * (k + 1));
        cfg_write(5, 0, 0);
        cfg_write(0, 7, 0);
        ready_level = 1'b0;
        rand_vec(); vecbuf[2] = 45; send_vec();
        check("thr_prog_field2", int'(m_vec[8:6]), 4);
        ready_level = 1'b1;
        wait_drain();
        cfg_write(2, 0, 200);
        ready_level = 1'b0;
        rand_vec(); vecbuf[2] = 45; send_vec();
        check("thr_nonmono_field2", int'(m_vec[8:6]), 3);
        ready_level = 1'b1;
        wait_drain();
        // Write coinciding with the accept of the same entry
        send_beat(1, 1'b0); send_beat(2, 1'b0);
        cfg_we = 1'b1; cfg_feat = 3'd2; cfg_idx = 3'd1; cfg_data = 8'd100;
        send_beat(45, 1'b0); send_beat(3, 1'b0); send_beat(4, 1'b1);
        rand_vec(); vecbuf[2] = 45; send_vec();
        wait_drain();

        // Reset with a pending output and a partial vector
        ready_level = 1'b0;
        rand_vec(); send_vec();
        send_beat(5, 1'b0); send_beat(6, 1'b0); send_beat(7, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_s_ready", int'(s_ready), 1);
        vecbuf = '{0, 31, 32, 223, 255};
        send_vec();
        check("midrst_default_vec", int'(m_vec), 15'h7C40);
        ready_level = 1'b1;
        wait_drain();

        // Back-to-back streaming
        out0 = n_out;
        first_acc = 0;
        for (int v = 0; v < 6; v++) begin
            rand_vec();
            for (int i = 0; i < 5; i++) begin
                send_beat(vecbuf[i], i == 4);
                if (v == 0 && i == 0) first_acc = last_acc_cyc;
            end
        end
        check("b2b_cycles", last_acc_cyc - first_acc, 29);
        wait_drain();
        check("b2b_outputs", n_out - out0, 6);

        // Randomized traffic with random back-pressure and table updates
        rnd_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 7) == 0) begin
                send_beat($urandom_range(0, 255), 1'b0);
                send_beat($urandom_range(0, 255), 1'b1);
            end
            rand_vec(); send_vec();
        end
        rnd_mode = 1'b0;
        ready_level = 1'b1;
        wait_drain();
        check("rand_err_flag", int'(err_frame), int'(err_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tnn_input_quantizer
`default_nettype wire

// File: doc/tnn_input_quantizer.md
Name: tnn_input_quantizer

Overview:
Upstream feed stage for the 5-input, 3-bit approximate TNN neurons in the AxLibrary flow, e.g. the whitewine 3-bit/4-neuron set.
- Accepts raw feature samples serially on a valid/ready stream.
- Quantizes each sample to 3 bits against a programmable per-feature threshold table.
- Packs five quantized features into one vector and presents it to the neuron array, which reads it as input_a..input_e, through a double-buffered valid/ready output.

Parameters:
N_FEAT, 5, features per vector (neuron fan-in)
IN_W, 8, raw feature sample width
Q_W, 3, quantized width; thresholds per feature = 2**Q_W-1 = 7

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  raw sample valid
s_ready  out  1  stage can accept a sample
s_data  in  IN_W  raw feature sample
s_last  in  1  marks final feature of a vector
m_valid  out  1  packed vector valid
m_ready  in  1  consumer accepts vector
m_vec  out  N_FEAT*Q_W  packed vector; feature i at [i*Q_W+:Q_W] (feature 0 = input_a)
cfg_we  in  1  threshold write strobe
cfg_feat  in  3  feature index for write (values >= N_FEAT ignored)
cfg_idx  in  3  threshold index 0..6 (7 ignored)
cfg_data  in  IN_W  threshold value
err_frame  out  1  sticky framing error flag
cfg_clr_err  in  1  clears err_frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, rst.
- Reset values:
  - m_valid=0, m_vec=0, err_frame=0, beat counter=0, collect buffer empty.
  - s_ready=1 from the first cycle after reset.
  - thr[f][k] = 32*(k+1) for all f, giving uniform bins.
- Quantization, combinational at accept time:
  - q = count of k in 0..6 with s_data >= thr[cnt][k], range 0..7.
  - Thresholds need not be monotonic; the count rule always applies.
- Accept: a sample is accepted when s_valid && s_ready. q is written to slot cnt of the collect register, and cnt increments.
- Frame end: the accepting beat with cnt==N_FEAT-1 completes the vector and cnt wraps to 0.
  - s_last must be 1 exactly on that beat.
  - s_last=1 with cnt<4, or s_last=0 with cnt==4: set err_frame, discard the partial vector, cnt=0, no output produced.
- Output register:
  - On completion, if the output register is empty or is draining in the same cycle (m_valid && m_ready), the vector loads into m_vec/m_valid next edge. Latency is 1 cycle from the last beat to m_valid.
  - Otherwise the vector is held in the collect register with collect_full=1.
- Ready: s_ready = !collect_full.
  - While the output register holds a vector, collection of the next vector proceeds.
  - collect_full clears, and the vector moves, on the edge where m_ready drains the output.
- Output stability: m_vec and m_valid stay stable while m_valid && !m_ready.
- Config writes:
  - Take effect on the next edge.
  - Writes during collection are legal; a sample uses the table value present on its accept edge.
  - Simultaneous write and accept to the same entry: the accept uses the old value.
- err_frame: stays set until cfg_clr_err or rst. If a set and a clear occur in the same cycle, set wins.
- Reset mid-frame: the partial vector and any pending output are dropped, and thresholds return to defaults.

Decomposition:
- Shared package tnn_pkg holds:
  - N_FEAT, IN_W, Q_W constants.
  - Threshold-table typedef, a 2-D array [N_FEAT][7] of IN_W.
  - Default-threshold function.
- One natural sub-module, tnn_thermo_count: the combinational 7-comparator population count. It is reused later for hidden-layer requantization.

Test Plan:
- Default table, vector raw {0,31,32,223,255} with s_last on the 5th beat -> m_vec fields {0,0,1,6,7}, i.e. m_vec=15'b111_110_001_000_000, m_valid 1 cycle after the last beat.
- Hold m_ready=0, stream two full vectors -> first is held stable on m_vec, second is collected, then s_ready=0; a third vector's first beat is stalled. Raise m_ready -> second vector appears next cycle and s_ready returns to 1.
- s_last asserted on the 3rd beat -> err_frame=1, no m_valid. The next clean 5-beat vector is output correctly; cfg_clr_err clears the flag.
- Program thr[2] = {10,20,30,40,50,60,70}, send 45 as feature 2 -> field 2 = 4. Non-monotonic thr[2][0]=200 with the same sample -> field 2 = 3.
- Assert rst after 3 beats with a pending output -> next cycle m_valid=0, s_ready=1, defaults restored; a following vector quantizes with the default table.
- Back-to-back vectors with m_ready tied 1 and s_valid continuous -> one vector per 5 cycles and no lost beats.
